// File: rtl/echo_capture_if.sv
// Host read port of the echo capture buffer: address/strobe in, one-cycle-late data/qualifier out.
interface echo_capture_if #(
   parameter int ADDR_W = 10,
   parameter int ACC_W  = 32
);
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [ACC_W-1:0]  rd_data;
   logic              rd_valid;

   modport master (output rd_en, rd_addr, input rd_data, rd_valid);
   modport slave  (input rd_en, rd_addr, output rd_data, rd_valid);
endinterface

// File: rtl/echo_capture.sv
// Gated ADC capture with decimation and coherent multi-shot accumulation into a signed buffer.
// One RAM read port is shared: the capture RMW owns it in CAPTURE, the host owns it when idle.
module echo_capture #(
   parameter int SAMPLE_W = 16,
   parameter int ACC_W    = 32,
   parameter int ADDR_W   = 10
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic                rx,
   input  logic [31:0]         record_len,
   input  logic [15:0]         decim,
   input  logic [15:0]         num_avg,
   input  logic [SAMPLE_W-1:0] adc_data,
   input  logic                adc_valid,
   echo_capture_if.slave       rd_if,
   output logic                busy,
   output logic                done,
   output logic [15:0]         shot_count,
   output logic                overflow,
   output logic                short_err
);
   typedef enum logic [2:0] {S_IDLE, S_ARM, S_CAPTURE, S_GAP, S_DONE} state_t;

   localparam int          SUM_W = ACC_W + 1;
   localparam logic [31:0] DEPTH = 32'(1) << ADDR_W;

   state_t                      r_state, w_next;
   logic                        r_en_d, r_rx_d;
   logic [ADDR_W:0]             r_len, r_idx;
   logic [15:0]                 r_decim, r_dcnt, r_navg, r_shot;
   logic                        r_ovf, r_short;
   logic                        r_wr_pend, r_wr_first, r_wr_last;
   logic [ADDR_W-1:0]           r_wr_addr;
   logic signed [SAMPLE_W-1:0]  r_wr_smp;
   logic [ACC_W-1:0]            r_q;
   logic                        r_rd_valid;
   logic [ACC_W-1:0]            r_mem [2**ADDR_W];

   logic                        w_en_rise, w_rx_rise, w_rx_fall;
   logic                        w_cap, w_take, w_last_wr, w_we, w_sat, w_start;
   logic signed [SUM_W-1:0]     w_sum;
   logic [ACC_W-1:0]            w_wdata;
   logic [ADDR_W-1:0]           w_raddr;

   assign w_en_rise = enable & ~r_en_d;
   assign w_rx_rise = rx & ~r_rx_d;
   assign w_rx_fall = ~rx & r_rx_d;
   assign w_cap     = (r_state == S_CAPTURE) && rx && adc_valid && (r_idx < r_len);
   assign w_take    = w_cap && (r_dcnt == r_decim);
   assign w_last_wr = r_wr_pend & r_wr_last;
   assign w_we      = r_wr_pend & enable;
   assign w_start   = w_en_rise && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_raddr   = (r_state == S_CAPTURE) ? r_idx[ADDR_W-1:0] : rd_if.rd_addr;

   // Saturating accumulate; shot 0 overwrites so the buffer needs no clear pass.
   always_comb begin
      w_sum   = $signed({r_q[ACC_W-1], r_q}) + SUM_W'(r_wr_smp);
      w_sat   = !r_wr_first && (w_sum[ACC_W] != w_sum[ACC_W-1]);
      w_wdata = w_sum[ACC_W-1:0];
      if (r_wr_first)
         w_wdata = ACC_W'(r_wr_smp);
      else if (w_sat)
         w_wdata = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
   end

   always_comb begin
      w_next = r_state;
      if (!enable)
         w_next = S_IDLE;
      else begin
         case (r_state)
            S_IDLE:    if (w_en_rise) w_next = S_ARM;
            S_ARM:     if (w_rx_rise) w_next = S_CAPTURE;
            S_CAPTURE: if (w_last_wr || w_rx_fall) w_next = S_GAP;
            S_GAP:     if (!rx) w_next = (r_shot == r_navg) ? S_DONE : S_ARM;
            S_DONE:    if (w_en_rise) w_next = S_ARM;
            default:   w_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_en_d     <= 1'b0;
         r_rx_d     <= 1'b0;
         r_len      <= '0;
         r_idx      <= '0;
         r_decim    <= '0;
         r_dcnt     <= '0;
         r_navg     <= '0;
         r_shot     <= '0;
         r_ovf      <= 1'b0;
         r_short    <= 1'b0;
         r_wr_pend  <= 1'b0;
         r_wr_first <= 1'b0;
         r_wr_last  <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_smp   <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_en_d     <= enable;
         r_rx_d     <= rx;
         r_rd_valid <= rd_if.rd_en & ~busy;
         if (w_start) begin
            if (record_len == 32'd0)
               r_len <= (ADDR_W+1)'(1);
            else if (record_len >= DEPTH)
               r_len <= DEPTH[ADDR_W:0];
            else
               r_len <= record_len[ADDR_W:0];
            r_decim <= decim;
            r_navg  <= (num_avg == 16'd0) ? 16'd1 : num_avg;
            r_shot  <= '0;
            r_ovf   <= 1'b0;
            r_short <= 1'b0;
         end
         if (r_state == S_ARM && w_next == S_CAPTURE) begin
            r_idx  <= '0;
            r_dcnt <= '0;
         end else if (w_cap && enable) begin
            if (w_take) begin
               r_idx  <= r_idx + (ADDR_W+1)'(1);
               r_dcnt <= '0;
            end else
               r_dcnt <= r_dcnt + 16'd1;
         end
         r_wr_pend  <= w_take & enable;
         r_wr_addr  <= r_idx[ADDR_W-1:0];
         r_wr_smp   <= adc_data;
         r_wr_first <= (r_shot == 16'd0);
         r_wr_last  <= (r_idx == r_len - (ADDR_W+1)'(1));
         if (w_we && w_sat)
            r_ovf <= 1'b1;
         if (r_state == S_CAPTURE && w_next == S_GAP) begin
            r_shot <= r_shot + 16'd1;
            if (!w_last_wr && r_idx < r_len)
               r_short <= 1'b1;
         end
      end
   end

   // Buffer is deliberately outside reset: contents survive reset and start.
   always_ff @(posedge clk) begin
      if (w_we)
         r_mem[r_wr_addr] <= w_wdata;
      r_q <= r_mem[w_raddr];
   end

   assign busy             = (r_state == S_ARM) || (r_state == S_CAPTURE) || (r_state == S_GAP);
   assign done             = (r_state == S_DONE);
   assign shot_count       = r_shot;
   assign overflow         = r_ovf;
   assign short_err        = r_short;
   assign rd_if.rd_valid   = r_rd_valid;
   assign rd_if.rd_data    = r_rd_valid ? r_q : '0;
endmodule

// File: tb/tb_echo_capture.sv
// Scoreboard bench for echo_capture: a 32-bit instance plus a 17-bit accumulator instance for saturation.
module tb_echo_capture;
   logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, rx = 1'b0, adc_valid = 1'b0;
   logic [31:0] record_len = '0;
   logic [15:0] decim = '0, num_avg = '0, adc_data = '0;
   logic        busy, done, overflow, short_err;
   logic [15:0] shot_count;
   logic        busy_s, done_s, overflow_s, short_err_s;
   logic [15:0] shot_count_s;

   int          checks = 0, errors = 0;
   logic [31:0] exp_q[$];
   logic [16:0] exp_s[$];
   logic [31:0] e;
   logic [16:0] es;

   echo_capture_if #(.ADDR_W(10), .ACC_W(32)) rif();
   echo_capture_if #(.ADDR_W(10), .ACC_W(17)) rif_s();
   assign rif_s.rd_en   = rif.rd_en;
   assign rif_s.rd_addr = rif.rd_addr;

   echo_capture u_dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .rx(rx), .record_len(record_len),
      .decim(decim), .num_avg(num_avg), .adc_data(adc_data), .adc_valid(adc_valid),
      .rd_if(rif), .busy(busy), .done(done), .shot_count(shot_count),
      .overflow(overflow), .short_err(short_err));

   echo_capture #(.ACC_W(17)) u_sat (
      .clk(clk), .rst_n(rst_n), .enable(enable), .rx(rx), .record_len(record_len),
      .decim(decim), .num_avg(num_avg), .adc_data(adc_data), .adc_valid(adc_valid),
      .rd_if(rif_s), .busy(busy_s), .done(done_s), .shot_count(shot_count_s),
      .overflow(overflow_s), .short_err(short_err_s));

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic start(input int len, input int dc, input int na);
      record_len = 32'(len); decim = 16'(dc); num_avg = 16'(na);
      enable = 1'b0; tick();
      enable = 1'b1; tick();
   endtask

   // mode 0: ramp val+i, 1: constant val, 2: steps 0,0,0,3,3,3,...
   task automatic gate(input int n, input int mode, input int val);
      rx = 1'b1; tick();
      for (int i = 0; i < n; i++) begin
         adc_valid = 1'b1;
         adc_data  = (mode == 0) ? 16'(val + i) : (mode == 1) ? 16'(val) : 16'(3 * (i / 3));
         tick();
      end
      adc_valid = 1'b0; tick(); tick();
      rx = 1'b0; tick(); tick();
   endtask

   task automatic rd_issue(input int a);
      rif.rd_en = 1'b1; rif.rd_addr = 10'(a); tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rif.rd_en = 1'b0; rif.rd_addr = '0;
      tick(); tick(); tick();
      checks++;
      if ({busy, done, shot_count, overflow, short_err, rif.rd_valid, rif.rd_data} !== '0) begin
         errors++;
         $display("FAIL reset: got busy=%b done=%b shots=%0d ovf=%b short=%b rv=%b rd=%h, expected all 0",
                  busy, done, shot_count, overflow, short_err, rif.rd_valid, rif.rd_data);
      end
      rst_n = 1'b1; tick();
   endtask

   task automatic test_basic();
      start(8, 0, 1);
      for (int i = 0; i < 8; i++) exp_q.push_back(32'(i));
      gate(8, 0, 0);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || shot_count !== 16'd1) begin
         errors++;
         $display("FAIL basic_status: got done=%b busy=%b shots=%0d, expected 1 0 1", done, busy, shot_count);
      end
      for (int i = 0; i < 8; i++) begin
         rd_issue(i);
         e = exp_q.pop_front(); checks++;
         if (rif.rd_valid !== 1'b1 || rif.rd_data !== e) begin
            errors++;
            $display("FAIL basic_bin%0d: got %h valid=%b, expected %h", i, rif.rd_data, rif.rd_valid, e);
         end
      end
      rif.rd_en = 1'b0;
   endtask

   task automatic test_decim();
      start(4, 2, 1);
      for (int i = 0; i < 4; i++) exp_q.push_back(32'(3 * i));
      gate(12, 2, 0);
      checks++;
      if (done !== 1'b1 || shot_count !== 16'd1) begin
         errors++;
         $display("FAIL decim_status: got done=%b shots=%0d, expected 1 1", done, shot_count);
      end
      for (int i = 0; i < 4; i++) begin
         rd_issue(i);
         e = exp_q.pop_front(); checks++;
         if (rif.rd_valid !== 1'b1 || rif.rd_data !== e) begin
            errors++;
            $display("FAIL decim_bin%0d: got %h valid=%b, expected %h", i, rif.rd_data, rif.rd_valid, e);
         end
      end
      rif.rd_en = 1'b0;
   endtask

   task automatic test_avg();
      start(4, 0, 3);
      for (int s = 1; s <= 3; s++) begin
         gate(4, 1, -5);
         checks++;
         if (shot_count !== 16'(s) || done !== (s == 3) || busy !== (s != 3)) begin
            errors++;
            $display("FAIL avg_shot%0d: got shots=%0d done=%b busy=%b, expected %0d %b %b",
                     s, shot_count, done, busy, s, s == 3, s != 3);
         end
         if (s == 1) begin
            rd_issue(0);
            checks++;
            if (rif.rd_valid !== 1'b0 || rif.rd_data !== 32'd0) begin
               errors++;
               $display("FAIL read_busy: got valid=%b data=%h, expected 0 0", rif.rd_valid, rif.rd_data);
            end
            rif.rd_en = 1'b0;
         end
      end
      for (int i = 0; i < 4; i++) exp_q.push_back(-32'sd15);
      for (int i = 0; i < 4; i++) begin
         rd_issue(i);
         e = exp_q.pop_front(); checks++;
         if (rif.rd_valid !== 1'b1 || rif.rd_data !== e) begin
            errors++;
            $display("FAIL avg_bin%0d: got %h valid=%b, expected %h", i, rif.rd_data, rif.rd_valid, e);
         end
      end
      rif.rd_en = 1'b0;
   endtask

   task automatic test_saturate();
      start(4, 0, 4);
      for (int s = 0; s < 4; s++) gate(4, 1, 16'h7FFF);
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(32'd131068);
         exp_s.push_back(17'd65535);
      end
      checks++;
      if (done_s !== 1'b1 || overflow_s !== 1'b1 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL sat_flags: got done17=%b ovf17=%b ovf32=%b, expected 1 1 0", done_s, overflow_s, overflow);
      end
      for (int i = 0; i < 4; i++) begin
         rd_issue(i);
         e = exp_q.pop_front(); es = exp_s.pop_front(); checks++;
         if (rif.rd_data !== e || rif_s.rd_data !== es || rif_s.rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL sat_bin%0d: got %h / %h, expected %h / %h", i, rif.rd_data, rif_s.rd_data, e, es);
         end
      end
      rif.rd_en = 1'b0;
   endtask

   task automatic test_short();
      start(6, 0, 2);
      rx = 1'b1; tick();
      adc_valid = 1'b1; adc_data = 16'd100; tick();
      adc_data = 16'd101; tick();
      adc_valid = 1'b0; rx = 1'b0; tick(); tick();
      checks++;
      if (short_err !== 1'b1 || shot_count !== 16'd1 || busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL short_flag: got short=%b shots=%0d busy=%b done=%b, expected 1 1 1 0",
                  short_err, shot_count, busy, done);
      end
      gate(6, 0, 10);
      // untouched bins 2..5 still hold earlier contents, so shot 2 adds onto them
      exp_q.push_back(32'd110);    exp_q.push_back(32'd112);
      exp_q.push_back(32'd131080); exp_q.push_back(32'd131081);
      exp_q.push_back(32'd18);     exp_q.push_back(32'd20);
      checks++;
      if (done !== 1'b1 || shot_count !== 16'd2 || short_err !== 1'b1) begin
         errors++;
         $display("FAIL short_done: got done=%b shots=%0d short=%b, expected 1 2 1", done, shot_count, short_err);
      end
      for (int i = 0; i < 6; i++) begin
         rd_issue(i);
         e = exp_q.pop_front(); checks++;
         if (rif.rd_valid !== 1'b1 || rif.rd_data !== e) begin
            errors++;
            $display("FAIL short_bin%0d: got %h valid=%b, expected %h", i, rif.rd_data, rif.rd_valid, e);
         end
      end
   endtask

   task automatic test_reset_mid();
      rif.rd_en = 1'b1; rif.rd_addr = '0;
      rst_n = 1'b0; tick(); tick();
      checks++;
      if ({busy, done, shot_count, overflow, short_err, rif.rd_valid, rif.rd_data} !== '0
          || overflow_s !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: got busy=%b done=%b shots=%0d ovf=%b short=%b rv=%b rd=%h, expected all 0",
                  busy, done, shot_count, overflow, short_err, rif.rd_valid, rif.rd_data);
      end
      rif.rd_en = 1'b0; enable = 1'b0;
      rst_n = 1'b1; tick();
   endtask

   task automatic test_abort();
      start(8, 0, 1);
      rx = 1'b1; tick();
      for (int i = 0; i < 3; i++) begin
         adc_valid = 1'b1; adc_data = 16'(50 + i); tick();
      end
      enable = 1'b0; adc_data = 16'd53; tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || shot_count !== 16'd0) begin
         errors++;
         $display("FAIL abort_state: got busy=%b done=%b shots=%0d, expected 0 0 0", busy, done, shot_count);
      end
      adc_data = 16'd54; tick();
      adc_valid = 1'b0; rx = 1'b0; tick();
      // write of the third sample was in flight at abort and must be dropped
      exp_q.push_back(32'd50); exp_q.push_back(32'd51);
      exp_q.push_back(32'd131080); exp_q.push_back(32'd131081);
      for (int i = 0; i < 4; i++) begin
         rd_issue(i);
         e = exp_q.pop_front(); checks++;
         if (rif.rd_valid !== 1'b1 || rif.rd_data !== e) begin
            errors++;
            $display("FAIL abort_bin%0d: got %h valid=%b, expected %h", i, rif.rd_data, rif.rd_valid, e);
         end
      end
      rif.rd_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_decim();
      test_avg();
      test_saturate();
      test_short();
      test_reset_mid();
      test_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
